hazard_forward_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_reg_decode.sv | 63 ++++++
 rtl/hazard_forward_unit.sv | 125 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - WISC opcodes, forward-select codes and pipeline shadow record type
package cpu_pkg;

    localparam int REG_W = 4;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             wen;
        logic             is_load;
    } stage_rec_t;

endpackage

// File: rtl/instr_reg_decode.sv
// rtl/instr_reg_decode.sv - combinational register-usage decode of one WISC instruction
module instr_reg_decode
    import cpu_pkg::*;
(
    input  logic [15:0]      instr,
    output logic [REG_W-1:0] srcA,
    output logic             srcA_v,
    output logic [REG_W-1:0] srcB,
    output logic             srcB_v,
    output logic [REG_W-1:0] dst,
    output logic             wen,
    output logic             is_load
);

    opcode_e op;

    assign op  = opcode_e'(instr[15:12]);
    assign dst = instr[11:8];

    always_comb begin
        srcA    = instr[7:4];
        srcA_v  = 1'b0;
        srcB    = instr[3:0];
        srcB_v  = 1'b0;
        wen     = 1'b0;
        is_load = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                srcA_v = 1'b1;
                srcB_v = 1'b1;
                wen    = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                srcA_v = 1'b1;
                wen    = 1'b1;
            end
            OP_LW: begin
                srcA_v  = 1'b1;
                wen     = 1'b1;
                is_load = 1'b1;
            end
            // SW reads its store data from the rd field
            OP_SW: begin
                srcA_v = 1'b1;
                srcB   = instr[11:8];
                srcB_v = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                srcA   = instr[11:8];
                srcA_v = 1'b1;
                wen    = 1'b1;
            end
            OP_BR: begin
                srcA_v = 1'b1;
            end
            OP_PCS: begin
                wen = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forward selects and load-use stall for the WISC pipeline
// Optional HAZARD_STATS_EN adds saturating stall_cnt/fwd_cnt outputs.
module hazard_forward_unit
    import cpu_pkg::*;
#(
    parameter int NREG        = 16,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_ID,
    input  logic        valid_ID,
    input  logic        flush,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        stall,
    output logic        bubble_EX
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] fwd_cnt
`endif
);

    if ($clog2(NREG) != REG_W) begin : g_bad_nreg
        $error("NREG must give a 4-bit register index");
    end

    logic [REG_W-1:0] src_a, src_b, id_dst;
    logic             src_a_v, src_b_v, id_wen, id_is_load;

    instr_reg_decode u_id_decode (
        .instr   (instr_ID),
        .srcA    (src_a),
        .srcA_v  (src_a_v),
        .srcB    (src_b),
        .srcB_v  (src_b_v),
        .dst     (id_dst),
        .wen     (id_wen),
        .is_load (id_is_load)
    );

    stage_rec_t ex_q, mem_q, wb_q;
    stage_rec_t ex_d;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic       bubble_q;
    logic       insert_bubble;
    logic       hit_a_ex, hit_b_ex, hit_a_mem, hit_b_mem;
    logic       wb_rec_unused;

    // The WB record is tracked for completeness; no forward path reads it.
    assign wb_rec_unused = ^wb_q;

    function automatic logic src_hit(input logic [REG_W-1:0] src, input logic v,
                                     input stage_rec_t rec);
        return v && rec.wen && (src == rec.dst) && !(ZERO_REG_EN && (src == '0));
    endfunction

    always_comb begin
        hit_a_ex  = src_hit(src_a, src_a_v, ex_q);
        hit_b_ex  = src_hit(src_b, src_b_v, ex_q);
        hit_a_mem = src_hit(src_a, src_a_v, mem_q);
        hit_b_mem = src_hit(src_b, src_b_v, mem_q);

        stall = valid_ID && !flush && ex_q.is_load && (hit_a_ex || hit_b_ex);
        insert_bubble = stall || flush || !valid_ID;

        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!insert_bubble) begin
            ex_d = '{dst: id_dst, wen: id_wen, is_load: id_is_load};
            // A load in EX can only reach here once it has moved to MEM, so it is excluded from the EX path.
            if (hit_a_ex && !ex_q.is_load) fwd_a_d = FWD_MEM;
            else if (hit_a_mem)            fwd_a_d = FWD_WB;
            if (hit_b_ex && !ex_q.is_load) fwd_b_d = FWD_MEM;
            else if (hit_b_mem)            fwd_b_d = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            bubble_q <= 1'b1;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= stall || flush;
        end
    end

    assign ForwardA  = fwd_a_q;
    assign ForwardB  = fwd_b_q;
    assign bubble_EX = bubble_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, fwd_cnt_q;
    logic        fwd_any_d;

    assign fwd_any_d = (fwd_a_d != FWD_RF) || (fwd_b_d != FWD_RF);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (fwd_any_d && (fwd_cnt_q != 16'hFFFF))
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed bench for hazard_forward_unit
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_ID;
    logic        valid_ID;
    logic        flush;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic        stall;
    logic        bubble_EX;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk       (clk),
        .rst       (rst),
        .instr_ID  (instr_ID),
        .valid_ID  (valid_ID),
        .flush     (flush),
        .ForwardA  (ForwardA),
        .ForwardB  (ForwardB),
        .stall     (stall),
        .bubble_EX (bubble_EX)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic v, input logic f);
        instr_ID = ins;
        valid_ID = v;
        flush    = f;
        #1;
    endtask

    task automatic idle(input int n);
        drive(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(16'h0000, 1'b0, 1'b0);
        tick();
        check("rst_fa", ForwardA, 2'b00);
        check("rst_fb", ForwardB, 2'b00);
        check("rst_bubble", {1'b0, bubble_EX}, 2'b01);
        check("rst_stall", {1'b0, stall}, 2'b00);
        rst = 1'b0;
        idle(2);

        // ADD r1,r2,r3 ; SUB r4,r1,r5
        drive(16'h0123, 1'b1, 1'b0); tick();
        drive(16'h1415, 1'b1, 1'b0);
        check("t1_stall", {1'b0, stall}, 2'b00);
        tick();
        check("t1_fa", ForwardA, 2'b10);
        check("t1_fb", ForwardB, 2'b00);
        check("t1_bubble", {1'b0, bubble_EX}, 2'b00);
        idle(3);

        // ADD r1,r2,r3 ; NOP ; XOR r6,r7,r1
        drive(16'h0123, 1'b1, 1'b0); tick();
        drive(16'h0000, 1'b0, 1'b0); tick();
        drive(16'h2671, 1'b1, 1'b0); tick();
        check("t2_fa", ForwardA, 2'b00);
        check("t2_fb", ForwardB, 2'b01);
        idle(3);

        // LW r2,r3,4 ; ADD r5,r2,r2
        drive(16'h8234, 1'b1, 1'b0); tick();
        drive(16'h0522, 1'b1, 1'b0);
        check("t3_stall1", {1'b0, stall}, 2'b01);
        tick();
        check("t3_bubble1", {1'b0, bubble_EX}, 2'b01);
        check("t3_fa_bub", ForwardA, 2'b00);
        check("t3_stall2", {1'b0, stall}, 2'b00);
        tick();
        check("t3_fa", ForwardA, 2'b01);
        check("t3_fb", ForwardB, 2'b01);
        check("t3_bubble2", {1'b0, bubble_EX}, 2'b00);
        idle(3);

        // ADD r1 ; ADD r1 ; SUB r8,r1,r1 -> nearest producer wins
        drive(16'h0123, 1'b1, 1'b0); tick();
        drive(16'h0145, 1'b1, 1'b0); tick();
        drive(16'h1811, 1'b1, 1'b0); tick();
        check("t4_fa", ForwardA, 2'b10);
        check("t4_fb", ForwardB, 2'b10);
        idle(3);

        // ADD r0,r2,r3 ; SUB r4,r0,r0 -> r0 never forwards
        drive(16'h0023, 1'b1, 1'b0); tick();
        drive(16'h1400, 1'b1, 1'b0);
        check("t5_r0_stall", {1'b0, stall}, 2'b00);
        tick();
        check("t5_r0_fa", ForwardA, 2'b00);
        check("t5_r0_fb", ForwardB, 2'b00);
        idle(3);

        // LW r2 ; SW r2,r4,0 -> store data from rd stalls, then WB forward
        drive(16'h8234, 1'b1, 1'b0); tick();
        drive(16'h9240, 1'b1, 1'b0);
        check("t5_sw_stall", {1'b0, stall}, 2'b01);
        tick();
        check("t5_sw_stall2", {1'b0, stall}, 2'b00);
        tick();
        check("t5_sw_fa", ForwardA, 2'b00);
        check("t5_sw_fb", ForwardB, 2'b01);
        idle(3);

        // LLB r3 reads rd ; B has no sources
        drive(16'h0312, 1'b1, 1'b0); tick();
        drive(16'hA3FF, 1'b1, 1'b0); tick();
        check("t5_llb_fa", ForwardA, 2'b10);
        drive(16'hC333, 1'b1, 1'b0); tick();
        check("t5_b_fa", ForwardA, 2'b00);
        check("t5_b_fb", ForwardB, 2'b00);
        idle(3);

        // LW r2 ; ADD r5,r2,r2 with flush -> flush wins
        drive(16'h8234, 1'b1, 1'b0); tick();
        drive(16'h0522, 1'b1, 1'b1);
        check("t6_fl_stall", {1'b0, stall}, 2'b00);
        tick();
        check("t6_fl_bubble", {1'b0, bubble_EX}, 2'b01);
        check("t6_fl_fa", ForwardA, 2'b00);
        check("t6_fl_fb", ForwardB, 2'b00);
        idle(3);

        // LW r2 ; ADD r5,r2,r2 with reset during the stall cycle
        drive(16'h8234, 1'b1, 1'b0); tick();
        drive(16'h0522, 1'b1, 1'b0);
        check("t6_rs_stall", {1'b0, stall}, 2'b01);
        rst = 1'b1;
        tick();
        check("t6_rs_fa", ForwardA, 2'b00);
        check("t6_rs_fb", ForwardB, 2'b00);
        check("t6_rs_bubble", {1'b0, bubble_EX}, 2'b01);
        check("t6_rs_stall2", {1'b0, stall}, 2'b00);
        rst = 1'b0;
        tick();
        check("t6_post_fa", ForwardA, 2'b00);
        check("t6_post_bubble", {1'b0, bubble_EX}, 2'b00);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
